// File: rtl/tvm_window_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tvm_window_reader_pkg
//  Description : Shared types and constants for the window reader: FSM state
//                encoding and the output FIFO depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package tvm_window_reader_pkg;

    // Depth of the output FIFO; the read credit rule is sized against it.
    localparam int FIFO_DEPTH = 2;
    // Width of the FIFO occupancy count (0..FIFO_DEPTH).
    localparam int FIFO_CNT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_VALID = 3'd1,
        ST_READ       = 3'd2,
        ST_ADVANCE    = 3'd3,
        ST_SETTLE     = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/tvm_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tvm_skid_fifo
//  Description : Two-entry FIFO with valid/ready on both sides. Entry 0 is
//                always the head, so the output is a register and stays
//                stable while the sink stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tvm_skid_fifo
    import tvm_window_reader_pkg::*;
#(
    parameter int WIDTH = 257
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]      mem_d [FIFO_DEPTH];
    logic [FIFO_CNT_W-1:0] count_q;
    logic [FIFO_CNT_W-1:0] count_d;
    logic                  push;
    logic                  pop;

    assign in_ready  = (count_q != FIFO_CNT_W'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[0];
    assign count     = count_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state: shift entry 1 to the head on pop, write the new entry into
    // the first slot that is free after the pop.
    always_comb begin
        mem_d = mem_q;
        if (pop) begin
            mem_d[0] = mem_q[1];
        end
        if (push) begin
            if ((count_q == 2'd0) || (pop && (count_q == 2'd1))) begin
                mem_d[0] = in_data;
            end else begin
                mem_d[1] = in_data;
            end
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Storage and occupancy registers; reset empties the FIFO and zeroes data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= '0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tvm_window_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tvm_window_reader
//  Description : Reads RD_WINDOW consecutive entries from a windowed buffer,
//                streams them out through a 2-entry FIFO under a read-credit
//                scheme, then pulses buf_read_advance to retire the window.
//                Optional macro TVM_WINDOW_READER_STATS_EN adds the
//                window_count output (advance pulses, wrapping).
//  Revision    : 1.0 - initial release
// ============================================================================
module tvm_window_reader
    import tvm_window_reader_pkg::*;
#(
    parameter int DATA_WIDTH    = 256,
    parameter int CNTR_WIDTH    = 10,
    parameter int RD_WINDOW     = 8,
    parameter int RD_ADDR_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     buf_read_valid,
    input  logic [DATA_WIDTH-1:0]    buf_read_data,
    output logic                     buf_read_ready,
    output logic [RD_ADDR_WIDTH-1:0] buf_read_addr,
    output logic                     buf_read_advance,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last
`ifdef TVM_WINDOW_READER_STATS_EN
    ,
    output logic [CNTR_WIDTH-1:0]    window_count
`endif
);

    // Parameter sanity: the offset counter must wrap exactly at the window.
    generate
        if (RD_WINDOW != (1 << RD_ADDR_WIDTH)) begin : g_bad_window
            $error("RD_WINDOW must equal 2**RD_ADDR_WIDTH");
        end
        if (CNTR_WIDTH < 1) begin : g_bad_cntr
            $error("CNTR_WIDTH must be at least 1");
        end
    endgenerate

    state_e                   state_q;
    state_e                   state_d;
    logic [RD_ADDR_WIDTH-1:0] offset_q;
    logic [RD_ADDR_WIDTH-1:0] offset_d;
    logic                     inflight_q;
    logic                     inflight_d;
    logic                     inflight_last_q;
    logic                     inflight_last_d;

    logic [FIFO_CNT_W-1:0]    fifo_count;
    logic                     fifo_in_ready;
    logic                     fifo_push;
    logic                     pop;
    logic [2:0]               occupancy;
    logic                     credit_ok;
    logic                     issue;
    logic                     offset_is_last;

    // A read may issue only if the entry it returns is guaranteed a FIFO slot:
    // stored entries plus the read still on the bus, less this cycle's pop.
    assign pop            = out_valid & out_ready;
    assign occupancy      = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign credit_ok      = (occupancy - {2'b00, pop}) < 3'(FIFO_DEPTH);
    assign issue          = (state_q == ST_READ) && credit_ok;
    assign offset_is_last = (offset_q == RD_ADDR_WIDTH'(RD_WINDOW - 1));

    assign buf_read_ready   = issue;
    assign buf_read_addr    = issue ? offset_q : '0;
    assign buf_read_advance = (state_q == ST_ADVANCE);

    // Window pass sequencing; a pass, once in READ, always runs to ADVANCE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (enable)                  state_d = ST_WAIT_VALID;
            ST_WAIT_VALID: if (buf_read_valid)          state_d = ST_READ;
            ST_READ:       if (issue && offset_is_last) state_d = ST_ADVANCE;
            ST_ADVANCE:                                 state_d = ST_SETTLE;
            ST_SETTLE:     state_d = enable ? ST_WAIT_VALID : ST_IDLE;
            default:                                    state_d = ST_IDLE;
        endcase
    end

    // Offset walks the window; the in-flight flag marks data due next cycle.
    always_comb begin
        offset_d = offset_q;
        if (issue) begin
            offset_d = offset_is_last ? '0 : offset_q + 1'b1;
        end
        inflight_d      = issue;
        inflight_last_d = issue & offset_is_last;
    end

    // Read-side state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            offset_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            offset_q        <= offset_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // Credit guarantees a free slot, so in_ready is always high on capture.
    assign fifo_push = inflight_q & fifo_in_ready;

    tvm_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fifo_push),
        .in_ready  (fifo_in_ready),
        .in_data   ({inflight_last_q, buf_read_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_last, out_data}),
        .count     (fifo_count)
    );

`ifdef TVM_WINDOW_READER_STATS_EN
    logic [CNTR_WIDTH-1:0] window_count_q;
    logic [CNTR_WIDTH-1:0] window_count_d;

    // One count per retired window, wrapping naturally.
    always_comb begin
        window_count_d = window_count_q;
        if (state_q == ST_ADVANCE) begin
            window_count_d = window_count_q + 1'b1;
        end
    end

    // Window counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window_count_q <= '0;
        end else begin
            window_count_q <= window_count_d;
        end
    end

    assign window_count = window_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/tvm_window_reader.md
TVM_WINDOW_READER -- requirements
Module: tvm_window_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, meaning width of buffer and output data.
REQ-002 SHALL have parameter CNTR_WIDTH, default 10, meaning width of the window counter.
REQ-003 SHALL have parameter RD_WINDOW, default 8, meaning number of entries read per window pass.
REQ-004 SHALL have parameter RD_ADDR_WIDTH, default 3, meaning log2(RD_WINDOW).
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, meaning start or continue window passes while high.
REQ-008 SHALL have port buf_read_valid, input, 1, meaning buffer holds at least RD_WINDOW entries.
REQ-009 SHALL have port buf_read_data, input, DATA_WIDTH, meaning buffer data, valid 1 cycle after buf_read_ready.
REQ-010 SHALL have port buf_read_ready, output, 1, meaning read strobe to buffer.
REQ-011 SHALL have port buf_read_addr, output, RD_ADDR_WIDTH, meaning window offset of the read.
REQ-012 SHALL have port buf_read_advance, output, 1, meaning 1-cycle pulse that retires the window.
REQ-013 SHALL have port out_valid, output, 1, meaning stream data valid.
REQ-014 SHALL have port out_ready, input, 1, meaning stream sink ready.
REQ-015 SHALL have port out_data, output, DATA_WIDTH, meaning stream payload.
REQ-016 SHALL have port out_last, output, 1, meaning payload is offset RD_WINDOW-1 of its window.

Function
REQ-017 SHALL implement FSM IDLE, WAIT_VALID, READ, ADVANCE, SETTLE.
REQ-018 IDLE->WAIT_VALID when enable=1; WAIT_VALID->READ when buf_read_valid=1.
REQ-019 In READ, SHALL assert buf_read_ready with buf_read_addr = 0..RD_WINDOW-1 in order, one per cycle when credit allows.
REQ-020 Credit rule: a read SHALL issue only if FIFO occupancy plus in-flight reads, less any pop this cycle, is below 2.
REQ-021 Returned data SHALL be captured 1 cycle after its strobe, tagged last when offset = RD_WINDOW-1.
REQ-022 After the last-offset read issues: READ->ADVANCE; buf_read_advance=1 for exactly 1 cycle; ADVANCE->SETTLE.
REQ-023 SETTLE SHALL last 1 cycle (buffer counter update), then go to WAIT_VALID if enable=1, else IDLE.
REQ-024 enable deassert mid-pass SHALL NOT abort the pass; the window completes and is advanced.
REQ-025 out_valid/out_data/out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 Throughput SHALL be 1 entry/cycle with out_ready held high; first output 2 cycles after entering READ.
REQ-027 buf_read_addr SHALL be 0 whenever buf_read_ready=0.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, empty FIFO, offset 0, in-flight 0, and all outputs to 0.
REQ-029 Reset mid-pass SHALL discard captured data; no advance pulse is issued.

Configuration
REQ-030 With TVM_WINDOW_READER_STATS_EN defined, SHALL add output window_count (CNTR_WIDTH), reset 0, +1 per advance pulse, wrapping modulo 2^CNTR_WIDTH.
REQ-031 Without TVM_WINDOW_READER_STATS_EN, window_count port and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package tvm_window_reader_pkg SHALL hold the FSM state enum and the FIFO depth constant (2).
REQ-033 The 2-entry output FIFO SHALL be sub-module tvm_skid_fifo (data+last, valid/ready both sides).

Verification
REQ-034 enable=1, buf_read_valid=1, out_ready=1 -> addr 0..7 on consecutive cycles, 8 outputs, out_last on the 8th, one advance pulse.
REQ-035 out_ready=0 for 5 cycles mid-pass -> at most 2 entries buffered, no read strobes, no data lost or duplicated.
REQ-036 buf_read_valid low 10 cycles -> WAIT_VALID held, no buf_read_ready asserted.
REQ-037 enable dropped at offset 3 -> offsets 4..7 still read, advance pulsed, FSM returns to IDLE.
REQ-038 rst=0 asserted at offset 5 -> all outputs 0 immediately, no advance pulse; after release with enable=1, pass restarts at offset 0.
REQ-039 STATS_EN, 3 full windows -> window_count=3.
